// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared types and constants for the multiply/divide sequencer.
//   WIDTH       : operand width (only 32 is supported)
//   ITER        : CALC iterations per operation (one result bit per cycle)
//   CNT_W       : iteration counter width (must hold 0..ITER)
//   mdu_op_e    : operation encoding driven on op_i
//   mdu_state_e : sequencer FSM states, also exported on state_o
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Magnitude of a two's complement value when en is set, else pass-through.
  // 32'h8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step -- one combinational iteration of the sequencer datapath.
//   div_sel  : (MDU_DIV_EN builds only) 1 = restoring-divide step, 0 = multiply
//   acc      : 64-bit accumulator. Multiply: {partial product, multiplier}.
//              Divide: {partial remainder, dividend/quotient}.
//   operand  : multiplicand (multiply) or divisor (divide), as magnitudes
//   acc_next : accumulator after this iteration
// Without MDU_DIV_EN only the shift-add multiply step exists.
module mdu_step
  import mdu_pkg::*;
(
`ifdef MDU_DIV_EN
  input  logic               div_sel,
`endif
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, keeping the carry, then shift right.
  logic [WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

`ifdef MDU_DIV_EN
  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor only when it fits; that decision is the quotient bit
  // that enters at the bottom as the dividend shifts out at the top.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
  assign fits   = (rem_sh >= {1'b0, operand});
  // Only consumed when fits, where the true difference is below 2^WIDTH.
  assign diff   = rem_sh[WIDTH-1:0] - operand;

  always_comb begin
    if (div_sel) begin
      acc_next = {(fits ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end
`else
  assign acc_next = {add_sum, acc[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer -- iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports:
//   clk, rst (sync, active-low)
//   start_i, op_i, rs_i, rt_i   : operation request, sampled only in IDLE
//   hi_we_i, lo_we_i, wdata_i   : MTHI/MTLO writes, honoured only in IDLE
//                                 and dropped when start_i is also high
//   busy_o                      : high in CALC and FIX
//   done_o, div0_o, err_o       : one-cycle result pulse and its flags (DONE)
//   hi_o, lo_o                  : architectural HI/LO
//   state_o                     : current FSM state (debug visibility)
// Handshake: start_i is a single-cycle request with no ready; it is accepted
// exactly when the FSM is in IDLE and ignored otherwise. Results appear on
// hi_o/lo_o in the same cycle done_o pulses.
// Build option: MDU_DIV_EN adds the restoring divider. Without it DIV/DIVU
// complete in one cycle with err_o set and HI/LO untouched.
// Timing for a start sampled at edge N: CALC N+1..N+32, FIX N+33, DONE N+34.
module mdu_sequencer #(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [WIDTH-1:0]    rs_i,
  input  logic [WIDTH-1:0]    rt_i,
  input  logic                hi_we_i,
  input  logic                lo_we_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o,
  output logic                div0_o,
  output logic                err_o,
  output mdu_pkg::mdu_state_e state_o
);

  import mdu_pkg::*;

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_next, prod_fix;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, abs_rs, abs_rt, res_hi, res_lo;
  logic               neg_lo_q;
  logic               start_div, start_signed;
`ifdef MDU_DIV_EN
  mdu_op_e            op_q;
  logic               neg_hi_q, div0_q;
  logic [WIDTH-1:0]   rs_q;
`else
  logic               err_q;
`endif

  assign start_div    = op_i[1];
  assign start_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign abs_rs       = abs_val(rs_i, start_signed);
  assign abs_rt       = abs_val(rt_i, start_signed);

  mdu_step u_step (
`ifdef MDU_DIV_EN
    .div_sel  (op_q[1]),
`endif
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_next)
  );

  // Next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef MDU_DIV_EN
          state_d = CALC;
`else
          state_d = start_div ? DONE : CALC;
`endif
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (op_q == MDU_DIV || op_q == MDU_DIVU) begin
      if (div0_q) begin
        res_hi = rs_q;
        res_lo = '1;
      end else begin
        // Quotient sign follows the operand signs, remainder follows rs.
        res_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
`ifdef MDU_DIV_EN
      op_q     <= MDU_MULT;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      rs_q     <= '0;
`else
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            // Start wins over a simultaneous MTHI/MTLO.
            cnt_q    <= '0;
            acc_q    <= {{WIDTH{1'b0}}, (start_div ? abs_rs : abs_rt)};
            opnd_q   <= start_div ? abs_rt : abs_rs;
            neg_lo_q <= start_signed & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
`ifdef MDU_DIV_EN
            op_q     <= mdu_op_e'(op_i);
            neg_hi_q <= start_signed & rs_i[WIDTH-1];
            div0_q   <= start_div && (rt_i == '0);
            rs_q     <= rs_i;
`else
            err_q    <= start_div;
`endif
          end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;
`ifdef MDU_DIV_EN
  assign div0_o  = done_o & div0_q;
  assign err_o   = 1'b0;
`else
  assign div0_o  = 1'b0;
  assign err_o   = done_o & err_q;
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer -- self-checking bench for mdu_sequencer.
// Expected {div0, err, hi, lo} words are computed by a behavioural model when
// an operation is driven and compared when done_o pulses, together with the
// start-to-done latency. Divide cases are selected by MDU_DIV_EN.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        hi_we_i = 1'b0;
  logic        lo_we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, div0_o, err_o;
  logic [31:0] hi_o, lo_o;
  mdu_state_e  state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .div0_o  (div0_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [65:0] exp_q[$];   // {div0, err, hi, lo}
  int          start_q[$];
  int          lat_q[$];
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] model(input logic [1:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt);
    logic [63:0] p;
    longint      a, b, q, r;
    logic [31:0] hi, lo;
    logic        dz, er;
    dz = 1'b0;
    er = 1'b0;
    a  = $signed(rs);
    b  = $signed(rt);
    p  = '0;
    q  = 0;
    r  = 0;
    if (op == 2'd0) begin
      p  = a * b;
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == 2'd1) begin
      p  = {32'd0, rs} * {32'd0, rt};
      hi = p[63:32];
      lo = p[31:0];
    end else begin
`ifdef MDU_DIV_EN
      if (rt == 32'd0) begin
        hi = rs;
        lo = 32'hFFFF_FFFF;
        dz = 1'b1;
      end else if (op == 2'd2) begin
        q  = a / b;
        r  = a % b;
        lo = q[31:0];
        hi = r[31:0];
      end else begin
        lo = rs / rt;
        hi = rs % rt;
      end
`else
      hi = mdl_hi;
      lo = mdl_lo;
      er = 1'b1;
`endif
    end
    return {dz, er, hi, lo};
  endfunction

  logic [65:0] mon_e;
  int          mon_s, mon_l;
  always @(negedge clk) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = start_q.pop_front();
        mon_l = lat_q.pop_front();
        check("hi", hi_o, mon_e[63:32]);
        check("lo", lo_o, mon_e[31:0]);
        check("div0", div0_o, mon_e[65]);
        check("err", err_o, mon_e[64]);
        check("latency", cyc + 1 - mon_s, mon_l);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic also_we);
    logic [65:0] e;
    @(negedge clk);
    op_i    = op;
    rs_i    = rs;
    rt_i    = rt;
    start_i = 1'b1;
    hi_we_i = also_we;
    lo_we_i = also_we;
    wdata_i = 32'hDEAD_BEEF;
    e = model(op, rs, rt);
    exp_q.push_back(e);
    lat_q.push_back(e[64] ? 1 : 34);
    mdl_hi = e[63:32];
    mdl_lo = e[31:0];
    @(posedge clk);
    #1;
    start_i = 1'b0;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    start_q.push_back(cyc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge clk);
    hi_we_i = whi;
    lo_we_i = wlo;
    wdata_i = d;
    @(posedge clk);
    #1;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    if (whi) mdl_hi = d;
    if (wlo) mdl_lo = d;
    @(negedge clk);
    check("mt_hi", hi_o, mdl_hi);
    check("mt_lo", lo_o, mdl_lo);
  endtask

  // ---------------- stimulus ----------------
  int          busy_cnt;
  logic [31:0] pre_hi, pre_lo, r_rs, r_rt;
  logic [1:0]  r_op;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_div0", div0_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_state", state_o, IDLE);
    rst = 1'b1;
    @(negedge clk);

    // Directed multiplies.
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_drain();
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, 33);
    wait_drain();
    issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_drain();
    issue(MDU_MULT, 32'd0, 32'h1234_5678, 1'b0);
    wait_drain();

`ifdef MDU_DIV_EN
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_drain();
    issue(MDU_DIVU, 32'd100, 32'd0, 1'b0);
    wait_drain();
    issue(MDU_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    wait_drain();
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_drain();
`else
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    issue(MDU_DIVU, 32'd10, 32'd3, 1'b0);
    wait_drain();
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_drain();
`endif

    // Random operations.
    for (int n = 0; n < 24; n++) begin
`ifdef MDU_DIV_EN
      r_op = 2'($urandom_range(0, 3));
`else
      r_op = 2'($urandom_range(0, 1));
`endif
      r_rs = $urandom;
      r_rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 17)) : $urandom;
      issue(r_op, r_rs, r_rt, 1'b0);
      wait_drain();
    end

    // Start together with MTHI/MTLO: the writes are dropped.
    mt_write(1'b1, 1'b1, 32'h1357_9BDF);
    pre_hi = hi_o;
    pre_lo = lo_o;
    issue(MDU_DIVU, 32'd55, 32'd7, 1'b1);
    @(negedge clk);
    check("start_we_hi", hi_o, pre_hi);
    check("start_we_lo", lo_o, pre_lo);
    wait_drain();

    // MTHI/MTLO while busy are ignored.
    mt_write(1'b1, 1'b1, 32'h1111_2222);
    issue(MDU_MULTU, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    hi_we_i = 1'b1;
    lo_we_i = 1'b1;
    wdata_i = 32'hCAFE_CAFE;
    @(posedge clk);
    #1;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    @(negedge clk);
    check("busy_we_hi", hi_o, 32'h1111_2222);
    check("busy_we_lo", lo_o, 32'h1111_2222);
    wait_drain();

    // Second start at start+5 is ignored.
    issue(MDU_MULT, 32'd1234, 32'd5678, 1'b0);
    repeat (4) @(negedge clk);
    op_i    = MDU_MULTU;
    rs_i    = 32'h7777_7777;
    rt_i    = 32'h0000_0099;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);

    // Reset mid-CALC aborts with no done pulse.
    @(negedge clk);
    op_i    = MDU_MULTU;
    rs_i    = 32'd7;
    rt_i    = 32'd9;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", state_o, IDLE);
    check("abort_hi", hi_o, 32'd0);
    check("abort_lo", lo_o, 32'd0);
    check("abort_busy", busy_o, 1'b0);
    rst = 1'b1;
    mdl_hi = '0;
    mdl_lo = '0;
    repeat (40) @(negedge clk);
    mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d limit=50000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
